// File: rtl/window_gen_dc_pkg.sv
// Shared helpers for the window generator and the PE blocks: counter sizing and tap indexing.
package window_gen_dc_pkg;

  // Width of a counter that must hold 0..n-1 (at least one bit).
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Flat tap position of window element (r, c); r=0 is the oldest row, c=0 the leftmost column.
  function automatic int unsigned tap_idx(input int unsigned r, input int unsigned c,
                                          input int unsigned fw);
    return r * fw + c;
  endfunction

endpackage

// File: rtl/window_gen_dc_if.sv
// Pixel-in / window-out stream bundle. The slave side is the window generator.
interface window_gen_dc_if #(
  parameter int unsigned D  = 512,
  parameter int unsigned FH = 3,
  parameter int unsigned FW = 3
);
  logic [D-1:0]         pix_in;
  logic                 pix_valid;
  logic                 pix_ready;
  logic [D*FH*FW-1:0]   win_out;
  logic                 win_valid;
  logic                 win_ready;
  logic                 win_last;

  modport master (
    output pix_in, pix_valid, win_ready,
    input  pix_ready, win_out, win_valid, win_last
  );

  modport slave (
    input  pix_in, pix_valid, win_ready,
    output pix_ready, win_out, win_valid, win_last
  );
endinterface

// File: rtl/line_buffer_dc.sv
// One image row of delay: reading slot col returns the pixel written at the same column one row
// earlier, and the new pixel overwrites it on accept.
module line_buffer_dc import window_gen_dc_pkg::*; #(
  parameter int unsigned D  = 512,
  parameter int unsigned W  = 16,
  localparam int unsigned CW = cnt_w(W)
) (
  input  logic          clk_i,
  input  logic          en_i,
  input  logic [CW-1:0] col_i,
  input  logic [D-1:0]  din_i,
  output logic [D-1:0]  dout_o
);

  logic [D-1:0] mem_q [W];

  // Read-before-write: the old row's pixel leaves as the new one enters.
  assign dout_o = mem_q[col_i];

  // Row storage write; contents need no reset since windows only form after a full refill.
  always_ff @(posedge clk_i) begin
    if (en_i) mem_q[col_i] <= din_i;
  end

endmodule

// File: rtl/window_gen_dc.sv
// Sliding FHxFW window generator over a raster pixel stream, single registered output stage.
module window_gen_dc import window_gen_dc_pkg::*; #(
  parameter int unsigned D     = 512,
  parameter int unsigned FH    = 3,
  parameter int unsigned FW    = 3,
  parameter int unsigned IMG_W = 16,
  parameter int unsigned IMG_H = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  window_gen_dc_if.slave  bus
);

  localparam int unsigned CW = cnt_w(IMG_W);
  localparam int unsigned RW = cnt_w(IMG_H);
  localparam int unsigned WW = D * FH * FW;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic          win_valid_q, win_valid_d;
  logic          win_last_q, win_last_d;
  logic [WW-1:0] win_out_q, win_out_d;
  logic [WW-1:0] taps;

  // stream[r] is the pixel in window row r at the current column; FH-1 is the live input.
  logic [FH-1:0][D-1:0]          stream;
  logic [FH-1:0][FW-2:0][D-1:0]  sh_q, sh_d;

  logic accept, form, col_end, row_end;

  assign bus.pix_ready = !win_valid_q || bus.win_ready;
  assign accept        = bus.pix_valid && bus.pix_ready && !clr;
  assign col_end       = (col_q == CW'(IMG_W - 1));
  assign row_end       = (row_q == RW'(IMG_H - 1));
  assign form          = (row_q >= RW'(FH - 1)) && (col_q >= CW'(FW - 1));
  assign stream[FH-1]  = bus.pix_in;

  assign bus.win_out   = win_out_q;
  assign bus.win_valid = win_valid_q;
  assign bus.win_last  = win_last_q;

  // Chain of row delays: each stage feeds the next-older window row.
  for (genvar k = 0; k < FH - 1; k++) begin : g_lb
    line_buffer_dc #(
      .D (D),
      .W (IMG_W)
    ) u_lb (
      .clk_i  (clk),
      .en_i   (accept),
      .col_i  (col_q),
      .din_i  (stream[FH-1-k]),
      .dout_o (stream[FH-2-k])
    );
  end

  // Per-row shift of the FW-1 previous columns; entry FW-2 is the most recent.
  always_comb begin
    sh_d = sh_q;
    if (accept) begin
      for (int unsigned r = 0; r < FH; r++) begin
        for (int unsigned j = 0; j + 1 < FW - 1; j++) sh_d[r][j] = sh_q[r][j+1];
        sh_d[r][FW-2] = stream[r];
      end
    end
  end

  // Assemble the window in PE bus order.
  always_comb begin
    taps = '0;
    for (int unsigned r = 0; r < FH; r++) begin
      for (int unsigned c = 0; c < FW - 1; c++) taps[tap_idx(r, c, FW)*D +: D] = sh_q[r][c];
      taps[tap_idx(r, FW - 1, FW)*D +: D] = stream[r];
    end
  end

  // Raster counters and output stage next-state.
  always_comb begin
    col_d       = col_q;
    row_d       = row_q;
    win_valid_d = win_valid_q;
    win_last_d  = win_last_q;
    win_out_d   = win_out_q;
    if (clr) begin
      col_d       = '0;
      row_d       = '0;
      win_valid_d = 1'b0;
      win_last_d  = 1'b0;
    end else begin
      if (bus.win_ready) begin
        win_valid_d = 1'b0;
        win_last_d  = 1'b0;
      end
      if (accept) begin
        if (col_end) begin
          col_d = '0;
          row_d = row_end ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
        // A new window may replace the one consumed this same cycle.
        if (form) begin
          win_valid_d = 1'b1;
          win_last_d  = col_end && row_end;
          win_out_d   = taps;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      row_q       <= '0;
      win_valid_q <= 1'b0;
      win_last_q  <= 1'b0;
      win_out_q   <= '0;
      sh_q        <= '0;
    end else begin
      col_q       <= col_d;
      row_q       <= row_d;
      win_valid_q <= win_valid_d;
      win_last_q  <= win_last_d;
      win_out_q   <= win_out_d;
      sh_q        <= sh_d;
    end
  end

endmodule
